// File: rtl/uart_rx_framer.sv
// rtl/uart_rx_framer.sv - UART receive framer: oversampling bit recovery plus output byte FIFO
//
// Optional feature macro: UART_RX_PARITY_EN (one even-parity bit after the data bits).
//
// Ports:
//   clk         in   rising-edge clock
//   reset       in   synchronous active-high reset
//   rx          in   asynchronous serial line, idle high
//   m_data      out  FIFO head byte (0 while empty)
//   m_valid     out  FIFO not empty
//   m_ready     in   consumer pops when m_valid && m_ready
//   busy        out  frame in progress
//   frame_err   out  one-cycle pulse: stop bit sampled low
//   parity_err  out  one-cycle pulse: parity mismatch (constant 0 without parity)
//   overrun     out  one-cycle pulse: good byte dropped, FIFO full
module uart_rx_framer #(
    parameter int CLK_DIV    = 4,
    parameter int OVERSAMPLE = 16,
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rx,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             busy,
    output logic             frame_err,
    output logic             parity_err,
    output logic             overrun
);

    localparam int DW = $clog2(CLK_DIV);
    localparam int SW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(WIDTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [SW-1:0] SMP_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] SMP_MID  = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    // ---------------- synchroniser ----------------
    logic rx_meta_q;
    logic rx_s_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // ---------------- framing FSM ----------------
    state_t           state_q;
    logic [DW-1:0]    div_q;
    logic [SW-1:0]    smp_q;
    logic [BW-1:0]    bit_q;
    logic [WIDTH-1:0] shift_q;
    logic             frame_err_q;
    logic             tick;
    logic             mid_tick;
    logic             bit_end;
    logic             par_bad;
    logic             wr_en;

    assign tick     = (div_q == DIV_LAST);
    assign mid_tick = tick && (smp_q == SMP_MID);
    assign bit_end  = tick && (smp_q == SMP_LAST);

`ifdef UART_RX_PARITY_EN
    logic par_q;
    logic parity_err_q;
    // Even parity: data bits and the parity bit must XOR to zero.
    assign par_bad    = ^{shift_q, par_q};
    assign parity_err = parity_err_q;
`else
    assign par_bad    = 1'b0;
    assign parity_err = 1'b0;
`endif

    // The byte is pushed combinationally in the stop-sample cycle so that
    // m_valid rises on the very next cycle.
    assign wr_en = (state_q == S_STOP) && bit_end && rx_s_q && !par_bad;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            div_q       <= '0;
            smp_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q        <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            // Held at zero in IDLE so the tick phase restarts with each frame.
            if (state_q == S_IDLE || tick) begin
                div_q <= '0;
            end else begin
                div_q <= div_q + 1'b1;
            end

            // Sample counter wraps on its own at the end of each bit; the
            // START mid-bit exit is the only transition that needs a clear.
            if (tick) begin
                smp_q <= (smp_q == SMP_LAST) ? '0 : smp_q + 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    smp_q <= '0;
                    bit_q <= '0;
                    if (!rx_s_q) begin
                        state_q <= S_START;
                    end
                end
                S_START: begin
                    if (mid_tick) begin
                        smp_q   <= '0;
                        state_q <= rx_s_q ? S_IDLE : S_DATA;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        shift_q <= (shift_q >> 1) | (WIDTH'(rx_s_q) << (WIDTH - 1));
                        bit_q   <= bit_q + 1'b1;
                        if (bit_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= S_PARITY;
`else
                            state_q <= S_STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (bit_end) begin
                        par_q   <= rx_s_q;
                        state_q <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (bit_end) begin
                        state_q     <= S_IDLE;
                        frame_err_q <= !rx_s_q;
`ifdef UART_RX_PARITY_EN
                        parity_err_q <= par_bad;
`endif
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign frame_err = frame_err_q;

    // ---------------- output FIFO ----------------
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             overrun_q;
    logic             pop;
    logic             full;
    logic             push_ok;

    assign pop     = m_valid && m_ready;
    assign full    = (count_q == FULL_CNT);
    // A full FIFO still accepts a write when the head is popped in the same cycle.
    assign push_ok = wr_en && (!full || pop);

    always_comb begin
        count_d = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push_ok && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= shift_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
            end
            count_q   <= count_d;
            overrun_q <= wr_en && full && !pop;
        end
    end

    assign m_valid = (count_q != '0);
    assign m_data  = m_valid ? mem_q[rd_ptr_q] : '0;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_uart_rx_framer.sv
// tb/tb_uart_rx_framer.sv - self-checking bench for uart_rx_framer
`timescale 1ns/1ps
module tb_uart_rx_framer;

    localparam int BITP = 64;
    localparam int NV   = 6;

    logic       clk;
    logic       reset;
    logic       rx;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic       busy;
    logic       frame_err;
    logic       parity_err;
    logic       overrun;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    uart_rx_framer #(
        .CLK_DIV   (4),
        .OVERSAMPLE(16),
        .WIDTH     (8),
        .DEPTH     (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .busy      (busy),
        .frame_err (frame_err),
        .parity_err(parity_err),
        .overrun   (overrun)
    );

    typedef struct {
        logic [7:0] data;
        logic       stop_good;
        logic       par_flip;
        logic       exp_write;
        logic       exp_fe;
        logic       exp_pe;
    } vec_t;

    vec_t       vecs [NV];
    int         checks;
    int         errors;
    int         fe_cnt;
    int         pe_cnt;
    int         ov_cnt;
    logic [7:0] got_q [$];
    logic [7:0] exp_q [$];
    logic       hold_prev;
    logic [7:0] hold_data;
    logic       rand_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_bit(input logic v, input int cycles);
        rx = v;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_good, input logic par_flip);
        @(posedge clk);
        #1;
        drive_bit(1'b0, BITP);
        for (int i = 0; i < 8; i++) drive_bit(d[i], BITP);
`ifdef UART_RX_PARITY_EN
        drive_bit((^d) ^ par_flip, BITP);
`endif
        if (stop_good) begin
            drive_bit(1'b1, BITP);
        end else begin
            // Low long enough to cover the stop sample, then back to idle.
            drive_bit(1'b0, 40);
            drive_bit(1'b1, BITP - 40);
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (reset) begin
                hold_prev = 1'b0;
            end else begin
                if (hold_prev) begin
                    check("stall_valid", 32'(m_valid), 32'd1);
                    check("stall_data", 32'(m_data), 32'(hold_data));
                end
                if (m_valid && m_ready) got_q.push_back(m_data);
                if (frame_err) fe_cnt++;
                if (parity_err) pe_cnt++;
                if (overrun) ov_cnt++;
                hold_prev = m_valid && !m_ready;
                hold_data = m_data;
            end
        end
    endtask

    task automatic main_seq();
        int         n0;
        int         f0;
        int         p0;
        int         o0;
        int         efe;
        int         epe;
        logic       saw_busy;
        logic [7:0] d;
        logic       sg;
        logic       pf;
        logic       par_ok;
        int         gap;

        repeat (5) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_data", 32'(m_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_parity_err", 32'(parity_err), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);

        // ---- table-driven single frames, consumer always ready ----
        vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{8'h11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
`ifdef UART_RX_PARITY_EN
        vecs[3] = '{8'h03, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{8'h03, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{8'h5A, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
`else
        vecs[3] = '{8'h03, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
`endif
        @(posedge clk);
        #1 m_ready = 1'b1;
        for (int i = 0; i < NV; i++) begin
            n0 = got_q.size(); f0 = fe_cnt; p0 = pe_cnt; o0 = ov_cnt;
            send_frame(vecs[i].data, vecs[i].stop_good, vecs[i].par_flip);
            repeat (80) @(posedge clk);
            @(negedge clk);
            check($sformatf("row%0d_pops", i), 32'(got_q.size() - n0), 32'(vecs[i].exp_write));
            if (vecs[i].exp_write && got_q.size() > n0)
                check($sformatf("row%0d_data", i), 32'(got_q[n0]), 32'(vecs[i].data));
            check($sformatf("row%0d_frame_err", i), 32'(fe_cnt - f0), 32'(vecs[i].exp_fe));
            check($sformatf("row%0d_parity_err", i), 32'(pe_cnt - p0), 32'(vecs[i].exp_pe));
            check($sformatf("row%0d_overrun", i), 32'(ov_cnt - o0), 32'd0);
            check($sformatf("row%0d_busy", i), 32'(busy), 32'd0);
        end

        // ---- short low glitch on the line ----
        n0 = got_q.size(); f0 = fe_cnt; p0 = pe_cnt; o0 = ov_cnt;
        saw_busy = 1'b0;
        @(posedge clk);
        #1 rx = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (busy) saw_busy = 1'b1;
        end
        @(posedge clk);
        #1 rx = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check("glitch_busy_seen", 32'(saw_busy), 32'd1);
        check("glitch_busy_clear", 32'(busy), 32'd0);
        repeat (5) @(negedge clk);
        check("glitch_m_valid", 32'(m_valid), 32'd0);
        check("glitch_pops", 32'(got_q.size() - n0), 32'd0);
        check("glitch_errs", 32'((fe_cnt - f0) + (pe_cnt - p0) + (ov_cnt - o0)), 32'd0);

        // ---- overrun: five frames into a 4-deep FIFO with no consumer ----
        n0 = got_q.size(); o0 = ov_cnt; f0 = fe_cnt;
        @(posedge clk);
        #1 m_ready = 1'b0;
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b0);
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("ovr_pulses", 32'(ov_cnt - o0), 32'd1);
        check("ovr_frame_err", 32'(fe_cnt - f0), 32'd0);
        check("ovr_m_valid", 32'(m_valid), 32'd1);
        check("ovr_head", 32'(m_data), 32'h01);
        @(posedge clk);
        #1 m_ready = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("ovr_drain_cnt", 32'(got_q.size() - n0), 32'd4);
        for (int i = 0; i < 4; i++)
            if (n0 + i < got_q.size())
                check($sformatf("ovr_drain%0d", i), 32'(got_q[n0 + i]), 32'(i + 1));
        check("ovr_empty", 32'(m_valid), 32'd0);

        // ---- reset in data bit 4 while FIFO holds two bytes ----
        @(posedge clk);
        #1 m_ready = 1'b0;
        send_frame(8'h21, 1'b1, 1'b0);
        send_frame(8'h42, 1'b1, 1'b0);
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("rstmid_prefill", 32'(m_valid), 32'd1);
        @(posedge clk);
        #1;
        drive_bit(1'b0, BITP);
        for (int i = 0; i < 4; i++) drive_bit(1'(8'h55 >> i), BITP);
        drive_bit(1'b1, 30);
        reset = 1'b1;
        rx    = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rstmid_m_valid", 32'(m_valid), 32'd0);
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_m_data", 32'(m_data), 32'd0);
        n0 = got_q.size(); f0 = fe_cnt; p0 = pe_cnt;
        @(posedge clk);
        #1 m_ready = 1'b1;
        repeat (5) @(posedge clk);
        send_frame(8'h7E, 1'b1, 1'b0);
        repeat (80) @(posedge clk);
        @(negedge clk);
        check("rstmid_pops", 32'(got_q.size() - n0), 32'd1);
        if (got_q.size() > n0) check("rstmid_data", 32'(got_q[n0]), 32'h7E);
        check("rstmid_errs", 32'((fe_cnt - f0) + (pe_cnt - p0)), 32'd0);

        // ---- randomized frames against a frame-level model ----
        exp_q.delete();
        n0 = got_q.size(); f0 = fe_cnt; p0 = pe_cnt; o0 = ov_cnt;
        efe = 0; epe = 0;
        rand_done = 1'b0;
        fork
            begin
                for (int k = 0; k < 10; k++) begin
                    d  = 8'($urandom);
                    sg = ($urandom_range(0, 5) != 0);
                    pf = ($urandom_range(0, 3) == 0);
`ifdef UART_RX_PARITY_EN
                    par_ok = !pf;
`else
                    par_ok = 1'b1;
`endif
                    if (!sg) efe++;
                    if (!par_ok) epe++;
                    if (sg && par_ok) exp_q.push_back(d);
                    send_frame(d, sg, pf);
                    gap = sg ? int'($urandom_range(0, 20)) : 40 + int'($urandom_range(0, 20));
                    repeat (gap) @(posedge clk);
                    #1;
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1 m_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        m_ready = 1'b1;
        repeat (80) @(posedge clk);
        @(negedge clk);
        check("rand_count", 32'(got_q.size() - n0), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            if (n0 + i < got_q.size())
                check($sformatf("rand_data%0d", i), 32'(got_q[n0 + i]), 32'(exp_q[i]));
        check("rand_frame_err", 32'(fe_cnt - f0), 32'(efe));
        check("rand_parity_err", 32'(pe_cnt - p0), 32'(epe));
        check("rand_overrun", 32'(ov_cnt - o0), 32'd0);
        check("rand_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        rx        = 1'b1;
        m_ready   = 1'b0;
        checks    = 0;
        errors    = 0;
        fe_cnt    = 0;
        pe_cnt    = 0;
        ov_cnt    = 0;
        hold_prev = 1'b0;
        hold_data = 8'h00;
        rand_done = 1'b0;
        fork
            monitor();
            main_seq();
        join_any
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_framer.md
# uart_rx_framer

Receive-side framing stage of the UART. It consumes the asynchronous serial line, oversamples it against a local tick generator, and recognises start, data and stop bits. Each complete byte is written into a small output FIFO, which is drained by the consumer through a valid/ready handshake. Framing, parity and overrun conditions are reported as one-cycle pulses.

## Interface
- `CLK_DIV`, default 4: `clk` cycles per oversample tick (≥2).
- `OVERSAMPLE`, default 16: ticks per bit period (even, ≥4).
- `WIDTH`, default 8: data bits per frame.
- `DEPTH`, default 4: output FIFO entries (power of 2).
- `clk`, input, 1: sole clock. All logic is on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `rx`, input, 1: asynchronous serial line. Idle level is 1.
- `m_data`, output, `WIDTH`: FIFO head byte.
- `m_valid`, output, 1: FIFO not empty.
- `m_ready`, input, 1: consumer accepts `m_data` when `m_valid && m_ready`.
- `busy`, output, 1: a frame is in progress (state ≠ IDLE).
- `frame_err`, output, 1: one-cycle pulse when a stop bit is sampled as 0.
- `parity_err`, output, 1: one-cycle pulse on parity mismatch. Tied to 0 without `UART_RX_PARITY_EN`.
- `overrun`, output, 1: one-cycle pulse when a good byte is dropped because the FIFO is full.

## Operation
- **Synchroniser:** `rx` passes through 2 flops, both reset to 1. All decisions use the second flop (`rx_s`).
- **Tick generator:** a counter over 0..`CLK_DIV`-1 produces `tick` for one cycle when it wraps. It is cleared on leaving IDLE.
- **Sample counter:** counts ticks over 0..`OVERSAMPLE`-1. It is cleared on every state change.
- **State machine:** IDLE → START → DATA → [PARITY] → STOP → IDLE.
  - IDLE: when `rx_s` == 0, go to START and clear both counters.
  - START: on the tick where the sample count reaches `OVERSAMPLE/2-1` (mid-bit):
    - `rx_s` == 0: go to DATA.
    - `rx_s` == 1: treat as a glitch and return to IDLE with no flags.
  - DATA: every `OVERSAMPLE` ticks, sample `rx_s` into the shift register, LSB first. After `WIDTH` samples, go to PARITY if enabled, otherwise STOP.
  - PARITY: after `OVERSAMPLE` ticks, sample the parity bit, then go to STOP.
  - STOP: after `OVERSAMPLE` ticks, sample `rx_s` and always return to IDLE.
    - Stop bit == 0: pulse `frame_err`; the byte is not written.
    - Parity mismatch: pulse `parity_err`; the byte is not written.
    - Otherwise, write the byte to the FIFO.
  - If framing and parity errors occur together, both pulse and nothing is written.
- **FIFO:**
  - `DEPTH` entries with read and write pointers plus a `log2(DEPTH)+1`-bit count. Pointers wrap modulo `DEPTH`.
  - A pop occurs when `m_valid && m_ready`.
  - Write while full with no pop in the same cycle: the byte is dropped and `overrun` pulses.
  - Write while full with a pop in the same cycle: the write is accepted and the count is unchanged.
  - Write while empty: data is visible at `m_data` on the next cycle.
- **Output stability:** `m_data` and `m_valid` are stable while `m_valid && !m_ready`.

## Timing
- **Reset values:** `m_valid`=0, `m_data`=0, `busy`=0, all error pulses 0, state IDLE, FIFO empty, counters 0, sync flops 1.
- **Reset mid-frame:** the partial byte is abandoned and the FIFO contents are discarded.
- **Input latency:** 2 cycles from an `rx` edge to `rx_s`.
- **Start detection:** `busy` rises the cycle after `rx_s` first reads 0.
- **Bit timing:** one bit period is `CLK_DIV*OVERSAMPLE` cycles (64 by default). Data bit *n* is sampled `(n+1.5)*64` cycles after start detection, ±`CLK_DIV`.
- **Write latency:** `m_valid` rises 1 cycle after the stop-bit sample cycle.
- **Error pulses:** asserted in the cycle after the stop-bit sample.
- **Back-to-back frames:** a falling `rx_s` in the cycle right after returning to IDLE starts a new frame. No extra idle cycle is required.
- **Pop timing:** a pop in the same cycle as `m_valid` rising is legal.

## Configuration
- **`UART_RX_PARITY_EN` defined:**
  - The PARITY state is present.
  - One even-parity bit follows the data bits; the XOR of data and parity must be 0.
  - A mismatch pulses `parity_err`.
- **Not defined:**
  - There is no PARITY state and no parity bit in the frame.
  - `parity_err` is constant 0.

## Test plan
- Default parameters, frame 0xA5 (8N1, 64 cycles/bit), `m_ready`=1 → single pop with `m_data`=0xA5; no error pulses; `busy` low afterwards.
- `rx` low for 20 cycles, then high → no `m_valid`, no errors, `busy` back to 0 within 40 cycles.
- Frame 0x3C with stop bit driven 0 → `frame_err` pulses once; FIFO stays empty; the next good frame 0x11 is received correctly.
- `m_ready`=0, five back-to-back frames 0x01..0x05 → FIFO holds 0x01..0x04; `overrun` pulses once on 0x05. Raising `m_ready` then yields 0x01, 0x02, 0x03, 0x04 in order.
- `UART_RX_PARITY_EN` defined:
  - Frame 0x03 with parity bit 1 → `parity_err` pulses; nothing written.
  - Frame 0x03 with parity bit 0 → 0x03 delivered.
- Assert `reset` during data bit 4 of a frame while the FIFO holds 2 bytes → the next cycle shows `m_valid`=0, `busy`=0. A subsequent frame 0x7E is received cleanly.
